// File: rtl/elastic_addr_pipeline.sv
// Elastic {address,id} pipeline: DEPTH stages, each adding a fixed address offset, with
// per-stage bubble collapsing or lockstep stall, plus ID/all flush with a registered kill count.
module elastic_addr_pipeline #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4,
  parameter int DEPTH         = 4,
  parameter int OFFSET_STRIDE = 3,
  parameter int COLLAPSE      = 1,
  localparam int CNT_W        = $clog2(DEPTH + 2),
  localparam int OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic                     in_valid,
  output logic                     out_stall,
  input  logic                     in_flush,
  input  logic                     in_flush_all,
  input  logic [ID_WIDTH-1:0]      in_flush_id,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_valid,
  input  logic                     in_stall,
  output logic                     out_flush,
  output logic [CNT_W-1:0]         out_flush_count,
  output logic [OCC_W-1:0]         out_occupancy
);

  logic [ADDRESS_WIDTH-1:0] addr_p [DEPTH];
  logic [ID_WIDTH-1:0]      id_p   [DEPTH];
  logic [DEPTH-1:0]         vld_p;
  logic [DEPTH-1:0]         vld_nxt;
  logic [DEPTH-1:0]         kill;
  logic [DEPTH:0]           rdy;
  logic                     xfer;
  logic                     drop;

  function automatic logic [ADDRESS_WIDTH-1:0] stage_offset(input int s);
    return ADDRESS_WIDTH'((s + 1) * OFFSET_STRIDE);
  endfunction

  function automatic logic [CNT_W-1:0] flush_count(input logic [DEPTH-1:0] k, input logic d);
    logic [CNT_W-1:0] c;
    c = CNT_W'(d);
    for (int i = 0; i < DEPTH; i++) c = c + CNT_W'(k[i]);
    return c;
  endfunction

  function automatic logic [OCC_W-1:0] occupancy(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + OCC_W'(v[i]);
    return c;
  endfunction

  // Ready chain runs back from the consumer; the output entry that transfers is never killed.
  always_comb begin
    logic r;
    r    = !in_stall;
    rdy  = '0;
    kill = '0;
    rdy[DEPTH] = r;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (COLLAPSE != 0) r = !vld_p[s] | r;
      else               r = !in_stall;
      rdy[s] = r;
    end
    xfer = vld_p[DEPTH-1] & !in_stall;
    for (int s = 0; s < DEPTH; s++)
      kill[s] = in_flush & vld_p[s] & (in_flush_all | (id_p[s] == in_flush_id))
                & !((s == DEPTH - 1) & xfer);
    drop = in_flush & in_valid & r & (in_flush_all | (in_id == in_flush_id));
  end

  always_comb begin
    vld_nxt    = '0;
    vld_nxt[0] = rdy[0] ? (in_valid & !drop) : (vld_p[0] & !kill[0]);
    for (int s = 1; s < DEPTH; s++)
      vld_nxt[s] = rdy[s] ? (vld_p[s-1] & !kill[s-1]) : (vld_p[s] & !kill[s]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p           <= '0;
      out_flush       <= 1'b0;
      out_flush_count <= '0;
      out_occupancy   <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        addr_p[s] <= '0;
        id_p[s]   <= '0;
      end
    end else begin
      vld_p           <= vld_nxt;
      out_flush       <= in_flush;
      out_flush_count <= in_flush ? flush_count(kill, drop) : '0;
      out_occupancy   <= occupancy(vld_nxt);
      // stage 0: capture upstream only on acceptance
      if (rdy[0] & in_valid) begin
        addr_p[0] <= in_address + stage_offset(0);
        id_p[0]   <= in_id;
      end
      // stages 1..DEPTH-1: advance from the previous stage
      for (int s = 1; s < DEPTH; s++) begin
        if (rdy[s] & vld_p[s-1]) begin
          addr_p[s] <= addr_p[s-1] + stage_offset(s);
          id_p[s]   <= id_p[s-1];
        end
      end
    end
  end

  assign out_stall   = !rdy[0];
  assign out_address = addr_p[DEPTH-1];
  assign out_id      = id_p[DEPTH-1];
  assign out_valid   = vld_p[DEPTH-1];

endmodule

// File: tb/tb_elastic_addr_pipeline.sv
// Bench for elastic_addr_pipeline: a collapsing and a lockstep instance share stimulus and are
// each compared against an in-flight transaction queue model, plus directed scenario checks.
module tb_elastic_addr_pipeline;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] in_address;
  logic [3:0]  in_id, in_flush_id;
  logic        in_valid, in_flush, in_flush_all, in_stall;

  logic [31:0] o_addr  [2];
  logic [3:0]  o_id    [2];
  logic        o_valid [2];
  logic        o_stall [2];
  logic        o_flush [2];
  logic [2:0]  o_fcnt  [2];
  logic [2:0]  o_occ   [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Model: accepted-but-not-delivered transactions in order, {id, input address}
  logic [35:0] q0[$];
  logic [35:0] q1[$];
  logic        exp_fl [2];
  int          exp_cnt[2];

  elastic_addr_pipeline #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .DEPTH(4), .OFFSET_STRIDE(3), .COLLAPSE(1)) u_col (
    .clk(clk), .reset_n(reset_n), .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
    .out_stall(o_stall[0]), .in_flush(in_flush), .in_flush_all(in_flush_all), .in_flush_id(in_flush_id),
    .out_address(o_addr[0]), .out_id(o_id[0]), .out_valid(o_valid[0]), .in_stall(in_stall),
    .out_flush(o_flush[0]), .out_flush_count(o_fcnt[0]), .out_occupancy(o_occ[0]));

  elastic_addr_pipeline #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .DEPTH(4), .OFFSET_STRIDE(3), .COLLAPSE(0)) u_lck (
    .clk(clk), .reset_n(reset_n), .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
    .out_stall(o_stall[1]), .in_flush(in_flush), .in_flush_all(in_flush_all), .in_flush_id(in_flush_id),
    .out_address(o_addr[1]), .out_id(o_id[1]), .out_valid(o_valid[1]), .in_stall(in_stall),
    .out_flush(o_flush[1]), .out_flush_count(o_fcnt[1]), .out_occupancy(o_occ[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Before the edge: check combinational stall and delivered data, then apply this cycle's events.
  task automatic pre(input int k);
    logic [35:0] tq[$];
    logic [35:0] e;
    logic [31:0] wa;
    bit          want_stall, acc;
    int          n;
    if (k == 0) tq = q0; else tq = q1;
    want_stall = in_stall && (k == 1 || tq.size() == 4);
    chk($sformatf("out_stall%0d", k), o_stall[k], want_stall);
    if (tq.size() == 0) chk($sformatf("idle_valid%0d", k), o_valid[k], 0);
    if (o_valid[k] && !in_stall && tq.size() > 0) begin
      e  = tq.pop_front();
      wa = e[31:0] + 32'd30;
      chk($sformatf("out_address%0d", k), o_addr[k], wa);
      chk($sformatf("out_id%0d", k), o_id[k], e[35:32]);
    end
    acc = in_valid && !want_stall;
    n   = 0;
    if (in_flush) begin
      for (int i = tq.size() - 1; i >= 0; i--)
        if (in_flush_all || tq[i][35:32] == in_flush_id) begin
          tq.delete(i);
          n++;
        end
      if (acc && (in_flush_all || in_id == in_flush_id)) begin
        n++;
        acc = 0;
      end
    end
    if (acc) tq.push_back({in_id, in_address});
    exp_fl[k]  = in_flush;
    exp_cnt[k] = in_flush ? n : 0;
    if (k == 0) q0 = tq; else q1 = tq;
  endtask

  task automatic post(input int k);
    int sz;
    sz = (k == 0) ? q0.size() : q1.size();
    chk($sformatf("out_flush%0d", k), o_flush[k], exp_fl[k]);
    chk($sformatf("flush_count%0d", k), o_fcnt[k], exp_cnt[k]);
    chk($sformatf("occupancy%0d", k), o_occ[k], sz);
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) pre(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) post(k);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] id);
    in_valid   = v;
    in_address = a;
    in_id      = id;
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), o_valid[k], 0);
      chk($sformatf("%s_occ%0d", tag, k), o_occ[k], 0);
      chk($sformatf("%s_flush%0d", tag, k), o_flush[k], 0);
      chk($sformatf("%s_fcnt%0d", tag, k), o_fcnt[k], 0);
      chk($sformatf("%s_addr%0d", tag, k), o_addr[k], 0);
      chk($sformatf("%s_id%0d", tag, k), o_id[k], 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0);
    in_flush = 0; in_flush_all = 0; in_flush_id = 0; in_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // latency and offset sum
    drive(1, 32'h100, 4'd2); cycle(); drive(0, 0, 0);
    cycle(); cycle();
    for (int k = 0; k < 2; k++) chk($sformatf("t1_early%0d", k), o_valid[k], 0);
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t1_valid%0d", k), o_valid[k], 1);
      chk($sformatf("t1_addr%0d", k), o_addr[k], 32'h11E);
      chk($sformatf("t1_id%0d", k), o_id[k], 4'd2);
    end
    repeat (3) cycle();

    // bubble squeezing under downstream stall
    drive(1, 32'h200, 4'd1); cycle();
    drive(0, 0, 0);          cycle();
    drive(1, 32'h300, 4'd2); cycle();
    in_stall = 1;
    for (int i = 0; i < 4; i++) begin drive(1, 32'h400 + 32'(i * 16), 4'(3 + i)); cycle(); end
    chk("t2_occ_col", o_occ[0], 4);
    chk("t2_stall_col", o_stall[0], 1);
    chk("t2_occ_lck", o_occ[1], 2);
    drive(0, 0, 0); in_stall = 0;
    repeat (8) cycle();

    // flush by ID, then a back-to-back flush with no match
    drive(1, 32'h500, 4'd1); cycle();
    drive(1, 32'h510, 4'd2); cycle();
    drive(1, 32'h520, 4'd1); cycle();
    drive(1, 32'h530, 4'd3); cycle();
    drive(0, 0, 0); in_stall = 1; in_flush = 1; in_flush_id = 4'd1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t3_flush%0d", k), o_flush[k], 1);
      chk($sformatf("t3_count%0d", k), o_fcnt[k], 2);
      chk($sformatf("t3_occ%0d", k), o_occ[k], 2);
    end
    in_flush_id = 4'd7;
    cycle();
    for (int k = 0; k < 2; k++) chk($sformatf("t3_count_b2b%0d", k), o_fcnt[k], 0);
    in_flush = 0; in_stall = 0;
    repeat (6) cycle();

    // flush_all together with a matching input
    drive(1, 32'h600, 4'd4); cycle();
    drive(1, 32'h610, 4'd6); cycle();
    drive(1, 32'h620, 4'd7); cycle();
    drive(1, 32'h630, 4'd5); in_flush = 1; in_flush_all = 1; in_flush_id = 0;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t4_count%0d", k), o_fcnt[k], 4);
      chk($sformatf("t4_occ%0d", k), o_occ[k], 0);
    end
    drive(0, 0, 0); in_flush = 0; in_flush_all = 0;
    repeat (4) cycle();
    for (int k = 0; k < 2; k++) chk($sformatf("t4_valid%0d", k), o_valid[k], 0);

    // address wrap, then lockstep keeps bubbles while collapsing squeezes them
    drive(1, 32'hFFFF_FFF0, 4'd9); cycle(); drive(0, 0, 0);
    repeat (3) cycle();
    for (int k = 0; k < 2; k++) chk($sformatf("t5_wrap%0d", k), o_addr[k], 32'h0000_000E);
    repeat (2) cycle();
    drive(1, 32'h700, 4'd1); cycle();
    drive(0, 0, 0);          cycle();
    drive(1, 32'h710, 4'd2); cycle();
    drive(0, 0, 0); in_stall = 1;
    repeat (3) cycle();
    chk("t5_occ_lck", o_occ[1], 2);
    chk("t5_hold_lck", o_valid[1], 0);
    chk("t5_hold_col", o_valid[0], 1);
    in_stall = 0;
    cycle();
    chk("t5_r1_col", o_valid[0], 1);
    chk("t5_r1_lck", o_valid[1], 1);
    cycle();
    chk("t5_r2_col", o_valid[0], 0);
    chk("t5_r2_lck", o_valid[1], 0);
    cycle();
    chk("t5_r3_lck", o_valid[1], 1);
    repeat (3) cycle();

    // asynchronous reset mid-stream
    drive(1, 32'h800, 4'd1); cycle();
    drive(1, 32'h810, 4'd2); cycle();
    drive(1, 32'h820, 4'd3); cycle();
    drive(0, 0, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("t6_reset");
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("t6_noflush%0d", k), o_flush[k], 0);
    reset_n = 1'b1;
    drive(1, 32'h900, 4'd4); cycle(); drive(0, 0, 0);
    repeat (6) cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom, 4'($urandom_range(0, 3)));
      in_stall     = $urandom_range(0, 9) < 3;
      in_flush     = $urandom_range(0, 19) == 0;
      in_flush_all = $urandom_range(0, 9) < 3;
      in_flush_id  = 4'($urandom_range(0, 3));
      cycle();
    end
    drive(0, 0, 0); in_stall = 0; in_flush = 0; in_flush_all = 0;
    repeat (10) cycle();
    chk("drain_col", q0.size(), 0);
    chk("drain_lck", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
